plab5_mcore_net_msg_to_mem_resp_msg: RTL

//  Core-side receiver for the memory-response network: accepts a split network message (control/data halves,

---
 rtl/plab5_mcore_net_msg_to_mem_resp_msg_pkg.sv | 35 +++
 rtl/plab5_mcore_net_resp_queue2.sv | 117 +++++++++++
 rtl/plab5_mcore_net_msg_to_mem_resp_msg.sv | 88 ++++++++
 3 files changed

// File: rtl/plab5_mcore_net_msg_to_mem_resp_msg_pkg.sv
// Shared field widths and encodings for the memory-response network receiver:
// VC memory response message layout, VC network message layout and the
// state encoding of the 2-entry response queue.
package plab5_mcore_net_msg_to_mem_resp_msg_pkg;

  // VC memory message type field and its encodings
  localparam int VC_MEM_RESP_MSG_TYPE_NBITS = 3;
  localparam logic [VC_MEM_RESP_MSG_TYPE_NBITS-1:0] VC_MEM_MSG_TYPE_READ  = 3'd0;
  localparam logic [VC_MEM_RESP_MSG_TYPE_NBITS-1:0] VC_MEM_MSG_TYPE_WRITE = 3'd1;

  // Width of the len field: enough bits to count bytes in one data word
  function automatic int vc_mem_resp_msg_len_nbits(input int data_nbits);
    return $clog2(data_nbits / 8);
  endfunction

  // Full mem resp message width: {type, opaque, len, data}
  function automatic int vc_mem_resp_msg_nbits(input int opaque_nbits, input int data_nbits);
    return VC_MEM_RESP_MSG_TYPE_NBITS + opaque_nbits
         + vc_mem_resp_msg_len_nbits(data_nbits) + data_nbits;
  endfunction

  // Net msg width: {dest, src, opaque, payload}
  function automatic int vc_net_msg_nbits(input int payload_nbits, input int opaque_nbits,
                                          input int srcdest_nbits);
    return 2 * srcdest_nbits + opaque_nbits + payload_nbits;
  endfunction

  // Occupancy states of the 2-entry response queue
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } queue_state_e;

endpackage

// File: rtl/plab5_mcore_net_resp_queue2.sv
// 2-entry FIFO holding {control, data, domain} triples. Entry 0 is always the
// head and drives the dequeue side directly from registers, so the enqueue
// ready depends only on occupancy state, never on deq_rdy.
module plab5_mcore_net_resp_queue2
  import plab5_mcore_net_msg_to_mem_resp_msg_pkg::*;
#(
  parameter int p_ctl_nbits  = 13,
  parameter int p_data_nbits = 32
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    enq_val,
  output logic                    enq_rdy,
  input  logic [p_ctl_nbits-1:0]  enq_ctl,
  input  logic [p_data_nbits-1:0] enq_data,
  input  logic                    enq_domain,

  output logic                    deq_val,
  input  logic                    deq_rdy,
  output logic [p_ctl_nbits-1:0]  deq_ctl,
  output logic [p_data_nbits-1:0] deq_data,
  output logic                    deq_domain
);

  queue_state_e state, state_next;

  logic [p_ctl_nbits-1:0]  ctl0,  ctl1;
  logic [p_data_nbits-1:0] data0, data1;
  logic                    dom0,  dom1;

  logic enq_fire, deq_fire;
  logic load0, load1, shift;

  assign enq_rdy  = (state != Q_FULL);
  assign deq_val  = (state != Q_EMPTY);
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  assign deq_ctl    = ctl0;
  assign deq_data   = data0;
  assign deq_domain = dom0;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= Q_EMPTY;
    else       state <= state_next;
  end

  // Next-state and entry write-enable decode
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next = state;
    load0      = 1'b0;
    load1      = 1'b0;
    shift      = 1'b0;
    unique case (state)
      Q_EMPTY: begin
        if (enq_fire) begin
          state_next = Q_ONE;
          load0      = 1'b1;
        end
      end
      Q_ONE: begin
        if (enq_fire && !deq_fire) begin
          state_next = Q_FULL;
          load1      = 1'b1;
        end else if (deq_fire && !enq_fire) begin
          state_next = Q_EMPTY;
        end else if (enq_fire && deq_fire) begin
          // Head leaves while the new entry arrives: it becomes the head
          load0 = 1'b1;
        end
      end
      Q_FULL: begin
        if (deq_fire) begin
          state_next = Q_ONE;
          shift      = 1'b1;
        end
      end
      default: state_next = Q_EMPTY;
    endcase
  end

  // Entry storage; control, data and domain always move together
  always_ff @(posedge clk) begin
    // NOTE: the two entries are reset because their contents are visible on
    // the outputs, which must read zero after reset.
    if (reset) begin
      ctl0  <= '0;
      data0 <= '0;
      dom0  <= 1'b0;
      ctl1  <= '0;
      data1 <= '0;
      dom1  <= 1'b0;
    end else begin
      if (load0) begin
        ctl0  <= enq_ctl;
        data0 <= enq_data;
        dom0  <= enq_domain;
      end else if (shift) begin
        ctl0  <= ctl1;
        data0 <= data1;
        dom0  <= dom1;
      end
      if (load1) begin
        ctl1  <= enq_ctl;
        data1 <= enq_data;
        dom1  <= enq_domain;
      end
    end
  end

endmodule

// File: rtl/plab5_mcore_net_msg_to_mem_resp_msg.sv
// Core-side receiver for the memory-response network. Strips the net header,
// drops messages not addressed to this terminal (recording the event), and
// buffers the memory response with its domain tag in a 2-entry queue.
module plab5_mcore_net_msg_to_mem_resp_msg
  import plab5_mcore_net_msg_to_mem_resp_msg_pkg::*;
#(
  parameter int p_net_dest          = 0,
  parameter int p_num_ports         = 4,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 3,
  localparam int c_npc = vc_mem_resp_msg_nbits(p_mem_opaque_nbits, p_mem_data_nbits)
                       - p_mem_data_nbits,
  localparam int c_net_msg_cnbits = vc_net_msg_nbits(c_npc, p_net_opaque_nbits,
                                                     p_net_srcdest_nbits)
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic                        in_domain,
  input  logic [c_net_msg_cnbits-1:0] net_msg_control,
  input  logic [p_mem_data_nbits-1:0] net_msg_data,

  output logic                        out_val,
  input  logic                        out_rdy,
  output logic                        out_domain,
  output logic [c_npc-1:0]            mem_msg_control,
  output logic [p_mem_data_nbits-1:0] mem_msg_data,

  output logic                        err_misroute,
  output logic [7:0]                  misroute_count
);

  localparam int c_ns = p_net_srcdest_nbits;
  localparam logic [c_ns-1:0] c_my_dest = c_ns'(p_net_dest);

  // Header unpack: dest in the top bits, payload control in the low bits
  logic [c_ns-1:0]  dest;
  logic [c_npc-1:0] payload_ctl;
  logic             dest_ok;
  logic             in_fire;
  logic             misroute_fire;

  assign dest        = net_msg_control[c_net_msg_cnbits-1 -: c_ns];
  assign payload_ctl = net_msg_control[c_npc-1:0];
  assign dest_ok     = (dest == c_my_dest);
  assign in_fire     = in_val && in_rdy;
  assign misroute_fire = in_fire && !dest_ok;

  // Source id and net opaque carry no meaning for the cache and are dropped
  logic unused_hdr;
  assign unused_hdr = ^net_msg_control[c_net_msg_cnbits-c_ns-1:c_npc];

  // Misrouted messages are consumed but never enqueued; in_rdy is driven by
  // the queue alone, so a mismatched dest cannot stall the network
  plab5_mcore_net_resp_queue2 #(
    .p_ctl_nbits  (c_npc),
    .p_data_nbits (p_mem_data_nbits)
  ) resp_queue (
    .clk        (clk),
    .reset      (reset),
    .enq_val    (in_val && dest_ok),
    .enq_rdy    (in_rdy),
    .enq_ctl    (payload_ctl),
    .enq_data   (net_msg_data),
    .enq_domain (in_domain),
    .deq_val    (out_val),
    .deq_rdy    (out_rdy),
    .deq_ctl    (mem_msg_control),
    .deq_data   (mem_msg_data),
    .deq_domain (out_domain)
  );

  // Sticky misroute flag and saturating drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      err_misroute   <= 1'b0;
      misroute_count <= 8'd0;
    end else if (misroute_fire) begin
      err_misroute <= 1'b1;
      if (misroute_count != 8'hff) misroute_count <= misroute_count + 8'd1;
    end
  end

endmodule
